l2_arbiter: RTL and testbench

Two-port arbiter that shares one L2 interface between the instruction-cache controller (port 0) and the data-cache controller (port 1). Each L1 controller drives level-held read/write-back requests, as its Allocate/WriteBack states do, and waits for a completion pulse. The arbiter serialises the requests onto the single L2 port, routes the L2 completion back to the owning requester, and flags L2 transactions that hang.

---
 rtl/l2_arbiter.sv | 133 +++++++++++++
 tb/tb_l2_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Two-port L2 arbiter: serialises I-cache (port 0) and D-cache (port 1) line
// fills and write-backs onto one L2 port, with round-robin fairness and a watchdog.
module l2_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req0,
    input  logic              rd_req1,
    input  logic              wr_req0,
    input  logic              wr_req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LINE_W-1:0] wdata0,
    input  logic [LINE_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              done0,
    output logic              done1,
    output logic [LINE_W-1:0] rdata,
    output logic              l2_rd,
    output logic              l2_wr,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ack,
    input  logic              l2_write_done,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
    } state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] wd_cnt;

    logic req0;
    logic req1;
    logic win;
    logic win_wr;

    // Winner index: a lone requester wins; on a tie the port not granted last wins.
    function automatic logic pick_port(input logic r0, input logic r1, input logic lst);
        if (r0 && r1)
            return ~lst;
        return r1;
    endfunction

    always_comb begin
        req0   = rd_req0 | wr_req0;
        req1   = rd_req1 | wr_req1;
        win    = pick_port(req0, req1, last);
        // A port holding both requests gets its write-back served first.
        win_wr = win ? wr_req1 : wr_req0;
    end

    // Completions are routed combinationally so the requester leaves its wait
    // state on the same edge the arbiter returns to IDLE.
    assign ack0  = (state == WAIT_RD) && l2_ack        && grant[0];
    assign ack1  = (state == WAIT_RD) && l2_ack        && grant[1];
    assign done0 = (state == WAIT_WR) && l2_write_done && grant[0];
    assign done1 = (state == WAIT_WR) && l2_write_done && grant[1];
    assign rdata = l2_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            l2_rd       <= 1'b0;
            l2_wr       <= 1'b0;
            l2_addr     <= '0;
            l2_wdata    <= '0;
            last        <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant    <= win ? 2'b10 : 2'b01;
                        l2_addr  <= win ? addr1 : addr0;
                        l2_wdata <= win ? wdata1 : wdata0;
                        l2_wr    <= win_wr;
                        l2_rd    <= ~win_wr;
                        last     <= win;
                        wd_cnt   <= '0;
                        state    <= win_wr ? WAIT_WR : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (l2_ack) begin
                        l2_rd <= 1'b0;
                        grant <= 2'b00;
                        state <= IDLE;
                    end
                end
                WAIT_WR: begin
                    if (l2_write_done) begin
                        l2_wr <= 1'b0;
                        grant <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: begin
                    l2_rd <= 1'b0;
                    l2_wr <= 1'b0;
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase

            // Watchdog only flags a hung transaction; the arbiter keeps waiting.
            if (state == WAIT_RD || state == WAIT_WR) begin
                if (wd_cnt != WD_MAX)
                    wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_LAST)
                    timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: single read, tie fairness, write-before-read,
// stray completions, watchdog and mid-transaction reset.
module tb_l2_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int TMO    = 8;

    logic              clk;
    logic              reset;
    logic              rd_req0, rd_req1, wr_req0, wr_req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [LINE_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, done0, done1;
    logic [LINE_W-1:0] rdata;
    logic              l2_rd, l2_wr;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_ack, l2_write_done;
    logic [1:0]        grant;
    logic              timeout_err;

    int n_cmp;
    int n_bad;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .rd_req0(rd_req0), .rd_req1(rd_req1), .wr_req0(wr_req0), .wr_req1(wr_req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .rdata(rdata),
        .l2_rd(l2_rd), .l2_wr(l2_wr), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_ack(l2_ack), .l2_write_done(l2_write_done),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        rd_req0 = 0; rd_req1 = 0; wr_req0 = 0; wr_req1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        l2_rdata = '0; l2_ack = 0; l2_write_done = 0;
        step(); step();
        chk("rst_grant", 128'(grant), 128'(2'b00));
        chk("rst_l2_rd", 128'(l2_rd), 128'(0));
        chk("rst_l2_wr", 128'(l2_wr), 128'(0));
        chk("rst_tmo", 128'(timeout_err), 128'(0));
        chk("rst_addr", 128'(l2_addr), 128'(0));
        reset = 1'b0;

        // Single read on port 0: grant in cycles 2..5, ack in cycle 5.
        step();
        rd_req0 = 1; addr0 = 32'h0000_1800; settle();
        chk("rd_idle_grant", 128'(grant), 128'(2'b00));
        step();
        chk("rd_grant", 128'(grant), 128'(2'b01));
        chk("rd_l2_rd", 128'(l2_rd), 128'(1));
        chk("rd_l2_wr", 128'(l2_wr), 128'(0));
        chk("rd_addr", 128'(l2_addr), 128'(32'h0000_1800));
        chk("rd_no_ack_early", 128'(ack0), 128'(0));
        addr0 = 32'hDEAD_0000;
        step(); step();
        chk("rd_addr_stable", 128'(l2_addr), 128'(32'h0000_1800));
        chk("rd_l2_rd_held", 128'(l2_rd), 128'(1));
        step();
        l2_ack = 1; l2_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; settle();
        chk("rd_ack0", 128'(ack0), 128'(1));
        chk("rd_ack1", 128'(ack1), 128'(0));
        chk("rd_done0", 128'(done0), 128'(0));
        chk("rd_rdata", rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        step();
        l2_ack = 0; rd_req0 = 0; settle();
        chk("rd_after_grant", 128'(grant), 128'(2'b00));
        chk("rd_after_l2_rd", 128'(l2_rd), 128'(0));
        chk("rd_after_ack0", 128'(ack0), 128'(0));

        // Tie after reset: port 0, then port 1, then port 0 again.
        reset = 1; step(); reset = 0;
        rd_req0 = 1; rd_req1 = 1; addr0 = 32'h100; addr1 = 32'h200;
        step();
        chk("tie1_grant", 128'(grant), 128'(2'b01));
        chk("tie1_addr", 128'(l2_addr), 128'(32'h100));
        l2_ack = 1; settle();
        chk("tie1_ack0", 128'(ack0), 128'(1));
        chk("tie1_ack1", 128'(ack1), 128'(0));
        step();
        l2_ack = 0; rd_req0 = 0; settle();
        chk("tie1_idle", 128'(grant), 128'(2'b00));
        step();
        chk("tie2_grant", 128'(grant), 128'(2'b10));
        chk("tie2_addr", 128'(l2_addr), 128'(32'h200));
        l2_ack = 1; settle();
        chk("tie2_ack1", 128'(ack1), 128'(1));
        chk("tie2_ack0", 128'(ack0), 128'(0));
        step();
        l2_ack = 0; rd_req1 = 0;
        step();
        rd_req0 = 1; rd_req1 = 1;
        step();
        chk("tie3_grant", 128'(grant), 128'(2'b01));
        l2_ack = 1; step();
        l2_ack = 0; rd_req0 = 0;
        step();
        chk("tie3_then_p1", 128'(grant), 128'(2'b10));
        l2_ack = 1; step();
        l2_ack = 0; rd_req1 = 0;
        step();

        // Write-back before read on port 1.
        wr_req1 = 1; rd_req1 = 1; addr1 = 32'h0000_4400;
        wdata1 = {16{8'hA5}};
        step();
        chk("wb_grant", 128'(grant), 128'(2'b10));
        chk("wb_l2_wr", 128'(l2_wr), 128'(1));
        chk("wb_l2_rd", 128'(l2_rd), 128'(0));
        chk("wb_wdata", l2_wdata, {16{8'hA5}});
        wdata1 = '0; step();
        chk("wb_wdata_stable", l2_wdata, {16{8'hA5}});
        l2_ack = 1; settle();
        chk("wb_stray_ack", 128'(ack1), 128'(0));
        step();
        l2_ack = 0;
        chk("wb_still_wr", 128'(l2_wr), 128'(1));
        l2_write_done = 1; settle();
        chk("wb_done1", 128'(done1), 128'(1));
        chk("wb_done0", 128'(done0), 128'(0));
        chk("wb_ack1", 128'(ack1), 128'(0));
        step();
        l2_write_done = 0; wr_req1 = 0;
        step();
        chk("wb_then_rd", 128'(l2_rd), 128'(1));
        chk("wb_then_rd_wr", 128'(l2_wr), 128'(0));
        chk("wb_then_rd_grant", 128'(grant), 128'(2'b10));
        l2_ack = 1; step();
        l2_ack = 0; rd_req1 = 0;
        step();

        // Stray completions: in IDLE and in WAIT_RD.
        l2_ack = 1; l2_write_done = 1; settle();
        chk("stray_idle_ack0", 128'(ack0), 128'(0));
        chk("stray_idle_done0", 128'(done0), 128'(0));
        step();
        l2_ack = 0; l2_write_done = 0;
        chk("stray_idle_grant", 128'(grant), 128'(2'b00));
        rd_req0 = 1; addr0 = 32'h0000_0040;
        step();
        chk("stray_rd_grant", 128'(grant), 128'(2'b01));
        l2_write_done = 1; settle();
        chk("stray_rd_done0", 128'(done0), 128'(0));
        chk("stray_rd_ack0", 128'(ack0), 128'(0));
        step();
        l2_write_done = 0;
        chk("stray_rd_held", 128'(l2_rd), 128'(1));
        chk("stray_rd_grant2", 128'(grant), 128'(2'b01));
        l2_ack = 1; step();
        l2_ack = 0; rd_req0 = 0;
        step();

        // Watchdog: grant visible in cycle g, error from g+TMO on.
        rd_req0 = 1;
        step();
        chk("wd_grant", 128'(grant), 128'(2'b01));
        chk("wd_clear", 128'(timeout_err), 128'(0));
        for (int i = 1; i < TMO; i++) step();
        chk("wd_before", 128'(timeout_err), 128'(0));
        step();
        chk("wd_at", 128'(timeout_err), 128'(1));
        step(); step();
        chk("wd_sticky", 128'(timeout_err), 128'(1));
        chk("wd_still_rd", 128'(l2_rd), 128'(1));
        l2_ack = 1; settle();
        chk("wd_late_ack0", 128'(ack0), 128'(1));
        step();
        l2_ack = 0; rd_req0 = 0;
        chk("wd_idle", 128'(grant), 128'(2'b00));
        chk("wd_sticky_idle", 128'(timeout_err), 128'(1));

        // Reset during WAIT_WR, then a tie must go to port 0 again.
        wr_req0 = 1; addr0 = 32'h0000_7700; wdata0 = 128'h55;
        step();
        chk("mr_l2_wr", 128'(l2_wr), 128'(1));
        reset = 1;
        step();
        reset = 0; wr_req0 = 0; settle();
        chk("mr_l2_wr_clr", 128'(l2_wr), 128'(0));
        chk("mr_grant_clr", 128'(grant), 128'(2'b00));
        chk("mr_tmo_clr", 128'(timeout_err), 128'(0));
        chk("mr_addr_clr", 128'(l2_addr), 128'(0));
        chk("mr_done0", 128'(done0), 128'(0));
        rd_req0 = 1; rd_req1 = 1;
        step();
        chk("mr_tie_grant", 128'(grant), 128'(2'b01));
        l2_ack = 1; step();
        l2_ack = 0; rd_req0 = 0; rd_req1 = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
